// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - APB3 register bus bundle for pwm_capture
// Purpose: carries the APB3 slave signals between a bus master and pwm_capture.
// Ports (members): PSEL, PENABLE, PWRITE, PADDR[31:0], PWDATA[31:0] from the master;
//                  PRDATA[31:0], PREADY, PSLVERR from the slave.
interface pwm_capture_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - servo PWM pulse-width / period capture with APB3 readout
// Purpose: measures high time and period of an asynchronous PWM input, flags
//          in-range pulses and lost signal, and exposes results over APB3.
// Ports: PCLK       - clock, all logic on rising edge
//        PRESET     - synchronous active-high reset
//        apb        - APB3 slave (PSEL/PENABLE/PWRITE/PADDR/PWDATA in, PRDATA/PREADY/PSLVERR out)
//        pwm_in     - asynchronous PWM input
//        sample_irq - one-cycle pulse per completed measurement
module pwm_capture #(
    parameter int unsigned PWM_TIMEOUT = 4000000,
    parameter int unsigned PW_MIN      = 100000,
    parameter int unsigned PW_MAX      = 200000
) (
    input  logic          PCLK,
    input  logic          PRESET,
    pwm_capture_if.slave  apb,
    input  logic          pwm_in,
    output logic          sample_irq
);

    localparam logic [31:0] TIMEOUT_C = 32'(PWM_TIMEOUT);
    localparam logic [31:0] PW_MIN_C  = 32'(PW_MIN);
    localparam logic [31:0] PW_MAX_C  = 32'(PW_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        s1;
    logic        s2;
    logic        s3;
    logic        rise;
    logic        fall;

    logic [31:0] hi_cnt;
    logic [31:0] per_cnt;
    logic [31:0] pw_pending;
    logic [31:0] pw_reg;
    logic [31:0] period_reg;
    logic [31:0] samples;
    logic        valid;
    logic        new_flag;
    logic        timeout_flag;
    logic        in_range;

    logic        do_start;
    logic        do_latch;
    logic        do_capture;
    logic        do_timeout;
    logic        timed_out;

    logic        rd_setup;
    logic        rd_status;
    logic        soft_clr;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign rise      = s2 & ~s3;
    assign fall      = ~s2 & s3;
    assign timed_out = (per_cnt >= TIMEOUT_C);

    assign rd_setup  = apb.PSEL & ~apb.PWRITE & ~apb.PENABLE;
    assign rd_status = apb.PSEL & ~apb.PWRITE & apb.PENABLE & (apb.PADDR[7:0] == 8'h08);
    assign soft_clr  = apb.PSEL & apb.PWRITE & apb.PENABLE & (apb.PADDR[7:0] == 8'h14);

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;

    // Write data and upper address bits carry no meaning for this block.
    assign unused_bits = ^{apb.PWDATA, apb.PADDR[31:8]};

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // A rise in LOW beats a simultaneous timeout; a soft clear beats everything.
    always_comb begin
        state_nxt  = state;
        do_start   = 1'b0;
        do_latch   = 1'b0;
        do_capture = 1'b0;
        do_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    do_start  = 1'b1;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (timed_out) begin
                    do_timeout = 1'b1;
                    state_nxt  = IDLE;
                end else if (fall) begin
                    do_latch  = 1'b1;
                    state_nxt = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    do_capture = 1'b1;
                    do_start   = 1'b1;
                    state_nxt  = HIGH;
                end else if (timed_out) begin
                    do_timeout = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (soft_clr) begin
            state_nxt  = IDLE;
            do_start   = 1'b0;
            do_latch   = 1'b0;
            do_capture = 1'b0;
            do_timeout = 1'b0;
        end
    end

    always_comb begin
        rd_mux = 32'hFFFF_FFFF;
        case (apb.PADDR[7:0])
            8'h00:   rd_mux = pw_reg;
            8'h04:   rd_mux = period_reg;
            8'h08:   rd_mux = {28'b0, timeout_flag, in_range, new_flag, valid};
            8'h0C:   rd_mux = samples;
            8'h10:   rd_mux = {31'b0, s2};
            default: rd_mux = 32'hFFFF_FFFF;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state        <= IDLE;
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            hi_cnt       <= '0;
            per_cnt      <= '0;
            pw_pending   <= '0;
            pw_reg       <= '0;
            period_reg   <= '0;
            samples      <= '0;
            valid        <= 1'b0;
            new_flag     <= 1'b0;
            timeout_flag <= 1'b0;
            in_range     <= 1'b0;
            sample_irq   <= 1'b0;
            apb.PRDATA   <= '0;
        end else begin
            s1         <= pwm_in;
            s2         <= s1;
            s3         <= s2;
            state      <= state_nxt;
            sample_irq <= do_capture;

            // Read data is frozen at setup so a same-cycle capture cannot tear it.
            if (rd_setup) begin
                apb.PRDATA <= rd_mux;
            end

            if (soft_clr) begin
                hi_cnt       <= '0;
                per_cnt      <= '0;
                pw_pending   <= '0;
                pw_reg       <= '0;
                period_reg   <= '0;
                samples      <= '0;
                valid        <= 1'b0;
                new_flag     <= 1'b0;
                timeout_flag <= 1'b0;
                in_range     <= 1'b0;
            end else begin
                if (do_start) begin
                    hi_cnt  <= 32'd1;
                    per_cnt <= 32'd1;
                end else if (state != IDLE) begin
                    hi_cnt  <= sat_inc(hi_cnt);
                    per_cnt <= sat_inc(per_cnt);
                end

                if (do_latch) begin
                    pw_pending <= hi_cnt;
                end

                if (do_capture) begin
                    pw_reg     <= pw_pending;
                    period_reg <= per_cnt;
                    valid      <= 1'b1;
                    samples    <= samples + 32'd1;
                    in_range   <= (pw_pending >= PW_MIN_C) && (pw_pending <= PW_MAX_C);
                end

                // A lost signal is no longer a valid or in-range signal.
                if (do_timeout) begin
                    valid        <= 1'b0;
                    in_range     <= 1'b0;
                    timeout_flag <= 1'b1;
                end else if (rd_status) begin
                    timeout_flag <= 1'b0;
                end

                if (do_capture) begin
                    new_flag <= 1'b1;
                end else if (rd_status) begin
                    new_flag <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture
module tb_pwm_capture;

    localparam int TO   = 5000;
    localparam int PMIN = 100;
    localparam int PMAX = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pwm_in = 1'b0;
    logic sample_irq;

    pwm_capture_if apb();

    pwm_capture #(
        .PWM_TIMEOUT(TO),
        .PW_MIN(PMIN),
        .PW_MAX(PMAX)
    ) dut (
        .PCLK(clk),
        .PRESET(rst),
        .apb(apb),
        .pwm_in(pwm_in),
        .sample_irq(sample_irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: captures are derived from the pulse list alone.
    logic [31:0] m_pw, m_per, m_smp;
    bit m_valid, m_new, m_to, m_inr, armed;
    int pend_h, pend_p;
    int exp_irq = 0;

    logic [31:0] rd_pw, rd_per, rd_st, rd_smp;
    logic [31:0] ex_pw, ex_per, ex_st, ex_smp;

    int irq_pulses = 0;
    int irq_cycles = 0;
    logic irq_prev = 1'b0;

    always @(negedge clk) begin
        if (sample_irq === 1'b1) irq_cycles++;
        if (sample_irq === 1'b1 && irq_prev !== 1'b1) irq_pulses++;
        irq_prev = sample_irq;
    end

    function automatic logic [31:0] m_status();
        return {28'b0, m_to, m_inr, m_new, m_valid};
    endfunction

    task automatic model_clear();
        m_pw = 0; m_per = 0; m_smp = 0;
        m_valid = 0; m_new = 0; m_to = 0; m_inr = 0; armed = 0;
    endtask

    task automatic model_rise(input int h, input int p);
        if (armed) begin
            m_pw    = 32'(pend_h);
            m_per   = 32'(pend_p);
            m_smp   = m_smp + 1;
            m_valid = 1;
            m_new   = 1;
            m_inr   = (pend_h >= PMIN) && (pend_h <= PMAX);
            exp_irq++;
        end
        armed  = 1;
        pend_h = h;
        pend_p = p;
    endtask

    task automatic model_after(input int p);
        if (p > TO) begin
            m_to = 1; m_valid = 0; m_inr = 0; armed = 0;
        end
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        apb.PSEL = 1; apb.PWRITE = 0; apb.PENABLE = 0; apb.PADDR = a;
        @(negedge clk);
        apb.PENABLE = 1;
        @(negedge clk);
        d = apb.PRDATA;
        apb.PSEL = 0; apb.PENABLE = 0;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        apb.PSEL = 1; apb.PWRITE = 1; apb.PENABLE = 0; apb.PADDR = a; apb.PWDATA = d;
        @(negedge clk);
        apb.PENABLE = 1;
        @(negedge clk);
        apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0;
    endtask

    task automatic read_all();
        ex_pw = m_pw; ex_per = m_per; ex_smp = m_smp; ex_st = m_status();
        apb_read(32'h00, rd_pw);
        apb_read(32'h04, rd_per);
        apb_read(32'h0C, rd_smp);
        apb_read(32'h08, rd_st);
        m_new = 0; m_to = 0;
    endtask

    task automatic drive(input int h, input int p);
        pwm_in = 1;
        repeat (h) @(negedge clk);
        pwm_in = 0;
        repeat (p - h) @(negedge clk);
    endtask

    task automatic send(input int h, input int p, input bit rd);
        model_rise(h, p);
        fork
            drive(h, p);
            begin
                if (rd) begin
                    repeat (10) @(negedge clk);
                    read_all();
                end
            end
        join
        model_after(p);
    endtask

    task automatic do_reset();
        pwm_in = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        model_clear();
    endtask

    task automatic test_reset();
        apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = 0; apb.PWDATA = 0;
        rst = 1;
        repeat (3) @(negedge clk);
        total++; if (apb.PRDATA !== 32'h0) begin bad++; $display("FAIL reset_prdata: got %0h want 0", apb.PRDATA); end
        total++; if (sample_irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", sample_irq); end
        total++; if (apb.PREADY !== 1'b1 || apb.PSLVERR !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b/%b want 1/0", apb.PREADY, apb.PSLVERR); end
        rst = 0;
        model_clear();
        read_all();
        total++; if (rd_pw !== 32'h0) begin bad++; $display("FAIL reset_pw: got %0h want 0", rd_pw); end
        total++; if (rd_per !== 32'h0) begin bad++; $display("FAIL reset_per: got %0h want 0", rd_per); end
        total++; if (rd_st !== 32'h0) begin bad++; $display("FAIL reset_status: got %0h want 0", rd_st); end
        total++; if (rd_smp !== 32'h0) begin bad++; $display("FAIL reset_samples: got %0h want 0", rd_smp); end
    endtask

    task automatic test_basic();
        do_reset();
        send(150, 2000, 0);
        send(150, 2000, 0);
        send(150, 2000, 1);
        total++; if (rd_pw !== ex_pw) begin bad++; $display("FAIL basic_pw: got %0d want %0d", rd_pw, ex_pw); end
        total++; if (rd_per !== ex_per) begin bad++; $display("FAIL basic_per: got %0d want %0d", rd_per, ex_per); end
        total++; if (rd_st !== ex_st) begin bad++; $display("FAIL basic_status: got %0h want %0h", rd_st, ex_st); end
        total++; if (rd_smp !== ex_smp) begin bad++; $display("FAIL basic_samples: got %0d want %0d", rd_smp, ex_smp); end
        total++; if (irq_pulses !== exp_irq || irq_cycles !== exp_irq) begin bad++; $display("FAIL basic_irq: got %0d pulses %0d cycles want %0d", irq_pulses, irq_cycles, exp_irq); end
        send(50, 2000, 0);
        send(150, 2000, 1);
        total++; if (rd_pw !== ex_pw) begin bad++; $display("FAIL short_pw: got %0d want %0d", rd_pw, ex_pw); end
        total++; if (rd_st !== ex_st) begin bad++; $display("FAIL short_status: got %0h want %0h", rd_st, ex_st); end
    endtask

    task automatic test_range();
        int hs[5];
        hs = '{99, 100, 200, 201, 60};
        do_reset();
        foreach (hs[i]) begin
            send(hs[i], 400, 1);
            total++; if (rd_pw !== ex_pw) begin bad++; $display("FAIL range_pw[%0d]: got %0d want %0d", i, rd_pw, ex_pw); end
            total++; if (rd_st !== ex_st) begin bad++; $display("FAIL range_status[%0d]: got %0h want %0h", i, rd_st, ex_st); end
        end
    endtask

    task automatic test_random();
        int h, p;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            h = $urandom_range(300, 20);
            p = $urandom_range(1500, h + 30);
            send(h, p, 1);
            total++; if (rd_pw !== ex_pw) begin bad++; $display("FAIL rand_pw[%0d]: got %0d want %0d", i, rd_pw, ex_pw); end
            total++; if (rd_per !== ex_per) begin bad++; $display("FAIL rand_per[%0d]: got %0d want %0d", i, rd_per, ex_per); end
            total++; if (rd_st !== ex_st) begin bad++; $display("FAIL rand_status[%0d]: got %0h want %0h", i, rd_st, ex_st); end
            total++; if (rd_smp !== ex_smp) begin bad++; $display("FAIL rand_samples[%0d]: got %0d want %0d", i, rd_smp, ex_smp); end
        end
        total++; if (irq_pulses !== exp_irq || irq_cycles !== exp_irq) begin bad++; $display("FAIL rand_irq: got %0d pulses %0d cycles want %0d", irq_pulses, irq_cycles, exp_irq); end
    endtask

    task automatic test_timeout();
        logic [31:0] v, e;
        do_reset();
        send(150, 2000, 0);
        send(150, 6000, 1);
        total++; if (rd_st !== ex_st) begin bad++; $display("FAIL to_pre_status: got %0h want %0h", rd_st, ex_st); end
        e = m_status();
        apb_read(32'h08, v);
        m_new = 0; m_to = 0;
        total++; if (v !== e) begin bad++; $display("FAIL to_status: got %0h want %0h", v, e); end
        apb_read(32'h00, v);
        total++; if (v !== m_pw) begin bad++; $display("FAIL to_pw_kept: got %0d want %0d", v, m_pw); end
        apb_read(32'h04, v);
        total++; if (v !== m_per) begin bad++; $display("FAIL to_per_kept: got %0d want %0d", v, m_per); end
        e = m_status();
        apb_read(32'h08, v);
        total++; if (v !== e) begin bad++; $display("FAIL to_status_cleared: got %0h want %0h", v, e); end
    endtask

    task automatic test_timeout_edge();
        do_reset();
        send(150, 2000, 0);
        send(150, TO, 0);
        send(150, 2000, 1);
        total++; if (rd_per !== ex_per) begin bad++; $display("FAIL edge_per: got %0d want %0d", rd_per, ex_per); end
        total++; if (rd_st !== ex_st) begin bad++; $display("FAIL edge_status: got %0h want %0h", rd_st, ex_st); end
        send(150, TO + 1, 0);
        send(150, 2000, 1);
        total++; if (rd_st !== ex_st) begin bad++; $display("FAIL edge_late_status: got %0h want %0h", rd_st, ex_st); end
        total++; if (rd_smp !== ex_smp) begin bad++; $display("FAIL edge_late_samples: got %0d want %0d", rd_smp, ex_smp); end
    endtask

    task automatic test_const_high();
        logic [31:0] v, e;
        do_reset();
        pwm_in = 1;
        repeat (TO + 100) @(negedge clk);
        m_to = 1;
        apb_read(32'h10, v);
        total++; if (v !== 32'h1) begin bad++; $display("FAIL high_raw: got %0h want 1", v); end
        e = m_status();
        apb_read(32'h08, v);
        m_new = 0; m_to = 0;
        total++; if (v !== e) begin bad++; $display("FAIL high_status: got %0h want %0h", v, e); end
        pwm_in = 0;
        repeat (10) @(negedge clk);
        apb_read(32'h10, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL low_raw: got %0h want 0", v); end
        send(150, 1000, 0);
        send(150, 1000, 1);
        total++; if (rd_smp !== ex_smp) begin bad++; $display("FAIL high_samples: got %0d want %0d", rd_smp, ex_smp); end
        total++; if (rd_pw !== ex_pw) begin bad++; $display("FAIL high_pw: got %0d want %0d", rd_pw, ex_pw); end
    endtask

    task automatic test_clear();
        do_reset();
        send(150, 1000, 0);
        send(150, 1000, 0);
        model_rise(150, 1000);
        fork
            drive(150, 1000);
            begin
                repeat (50) @(negedge clk);
                apb_write(32'h14, 32'hDEAD_BEEF);
            end
        join
        model_clear();
        read_all();
        total++; if (rd_pw !== ex_pw) begin bad++; $display("FAIL clr_pw: got %0d want %0d", rd_pw, ex_pw); end
        total++; if (rd_per !== ex_per) begin bad++; $display("FAIL clr_per: got %0d want %0d", rd_per, ex_per); end
        total++; if (rd_st !== ex_st) begin bad++; $display("FAIL clr_status: got %0h want %0h", rd_st, ex_st); end
        total++; if (rd_smp !== ex_smp) begin bad++; $display("FAIL clr_samples: got %0d want %0d", rd_smp, ex_smp); end
        // clear lands on the same edge the rise is acted upon
        fork
            drive(150, 1000);
            apb_write(32'h14, 32'h0);
        join
        model_clear();
        send(120, 900, 0);
        send(130, 1100, 1);
        total++; if (rd_pw !== ex_pw) begin bad++; $display("FAIL clr_after_pw: got %0d want %0d", rd_pw, ex_pw); end
        total++; if (rd_per !== ex_per) begin bad++; $display("FAIL clr_after_per: got %0d want %0d", rd_per, ex_per); end
        total++; if (rd_smp !== ex_smp) begin bad++; $display("FAIL clr_after_samples: got %0d want %0d", rd_smp, ex_smp); end
        model_rise(140, 1000);
        fork
            drive(140, 1000);
            begin
                repeat (400) @(negedge clk);
                rst = 1;
                @(negedge clk);
                rst = 0;
            end
        join
        model_clear();
        read_all();
        total++; if (rd_pw !== ex_pw || rd_per !== ex_per) begin bad++; $display("FAIL rst_regs: got %0d/%0d want %0d/%0d", rd_pw, rd_per, ex_pw, ex_per); end
        total++; if (rd_st !== ex_st || rd_smp !== ex_smp) begin bad++; $display("FAIL rst_status: got %0h/%0d want %0h/%0d", rd_st, rd_smp, ex_st, ex_smp); end
        send(160, 1000, 0);
        send(170, 1200, 1);
        total++; if (rd_pw !== ex_pw) begin bad++; $display("FAIL rst_after_pw: got %0d want %0d", rd_pw, ex_pw); end
        total++; if (rd_per !== ex_per) begin bad++; $display("FAIL rst_after_per: got %0d want %0d", rd_per, ex_per); end
        total++; if (rd_smp !== ex_smp) begin bad++; $display("FAIL rst_after_samples: got %0d want %0d", rd_smp, ex_smp); end
        total++; if (irq_pulses !== exp_irq || irq_cycles !== exp_irq) begin bad++; $display("FAIL clr_irq: got %0d pulses %0d cycles want %0d", irq_pulses, irq_cycles, exp_irq); end
    endtask

    task automatic test_coincide();
        logic [31:0] v, e;
        do_reset();
        send(150, 1000, 0);
        send(150, 1000, 1);
        e = m_status();
        model_rise(150, 1000);
        fork
            drive(150, 1000);
            apb_read(32'h08, v);
        join
        total++; if (v !== e) begin bad++; $display("FAIL coin_old: got %0h want %0h", v, e); end
        e = m_status();
        apb_read(32'h08, v);
        m_new = 0; m_to = 0;
        total++; if (v !== e) begin bad++; $display("FAIL coin_new: got %0h want %0h", v, e); end
    endtask

    task automatic test_misc();
        logic [31:0] v;
        logic [31:0] addrs[3];
        addrs = '{32'h20, 32'h1C, 32'hFF};
        foreach (addrs[i]) begin
            apb_read(addrs[i], v);
            total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL unmapped[%0h]: got %0h want ffffffff", addrs[i], v); end
        end
        apb_write(32'h00, 32'h1234_5678);
        apb_read(32'h100, v);
        total++; if (v !== m_pw) begin bad++; $display("FAIL alias_pw: got %0d want %0d", v, m_pw); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_range();
        test_random();
        test_timeout();
        test_timeout_edge();
        test_const_high();
        test_clear();
        test_coincide();
        test_misc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
